// File: rtl/cellrv32_npu_result_deskew.sv
// cellrv32_npu_result_deskew
// Realigns the diagonally skewed result stream of the NPU matrix multiply
// unit. Column j leaves the array j enabled cycles after column 0, so column j
// is delayed by MATRIX_WIDTH-j registers. That way every column of a row
// reaches the output in the same cycle. A tag pipeline carries the row's
// valid/address/accumulate information in lockstep with the column 0 chain.
module cellrv32_npu_result_deskew #(
    parameter int MATRIX_WIDTH = 14,
    parameter int ADDR_WIDTH   = 8,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   enable_i,
    input  logic [31:0]            result_i [0:MATRIX_WIDTH-1],
    input  logic                   res_valid_i,
    input  logic [ADDR_WIDTH-1:0]  res_addr_i,
    input  logic                   res_acc_i,
    output logic [31:0]            row_data_o [0:MATRIX_WIDTH-1],
    output logic                   row_valid_o,
    output logic [ADDR_WIDTH-1:0]  row_addr_o,
    output logic                   row_acc_o,
    output logic                   busy_o,
    output logic [COUNT_WIDTH-1:0] row_count_o
);

    localparam int TAG_STAGES = MATRIX_WIDTH - 1;

    // In-flight tag stages 0..MATRIX_WIDTH-2. The final tag stage is the
    // registered output (row_*_r) and is not counted towards busy.
    logic                  tag_valid_r [0:TAG_STAGES-1];
    logic [ADDR_WIDTH-1:0] tag_addr_r  [0:TAG_STAGES-1];
    logic                  tag_acc_r   [0:TAG_STAGES-1];

    logic                   row_valid_r;
    logic [ADDR_WIDTH-1:0]  row_addr_r;
    logic                   row_acc_r;
    logic [COUNT_WIDTH-1:0] row_count_r;
    logic                   busy_s;

    // Tag pipeline. The output valid is cleared on any stalled edge, so a row
    // is reported exactly once. Address and accumulate flag hold during stalls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < TAG_STAGES; i++) begin
                tag_valid_r[i] <= 1'b0;
                tag_addr_r[i]  <= '0;
                tag_acc_r[i]   <= 1'b0;
            end
            row_valid_r <= 1'b0;
            row_addr_r  <= '0;
            row_acc_r   <= 1'b0;
        end else if (enable_i) begin
            tag_valid_r[0] <= res_valid_i;
            tag_addr_r[0]  <= res_addr_i;
            tag_acc_r[0]   <= res_acc_i;
            for (int i = 1; i < TAG_STAGES; i++) begin
                tag_valid_r[i] <= tag_valid_r[i-1];
                tag_addr_r[i]  <= tag_addr_r[i-1];
                tag_acc_r[i]   <= tag_acc_r[i-1];
            end
            row_valid_r <= tag_valid_r[TAG_STAGES-1];
            row_addr_r  <= tag_addr_r[TAG_STAGES-1];
            row_acc_r   <= tag_acc_r[TAG_STAGES-1];
        end else begin
            row_valid_r <= 1'b0;
        end
    end

    // Per-column compensating delay chains, MATRIX_WIDTH-j registers deep.
    // Data is not gated on valid; consumers qualify on row_valid_o.
    for (genvar j = 0; j < MATRIX_WIDTH; j++) begin : g_col
        localparam int DEPTH = MATRIX_WIDTH - j;
        logic [31:0] chain_r [0:DEPTH-1];

        // Shift column j one stage per enabled edge; hold during stalls.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int k = 0; k < DEPTH; k++) begin
                    chain_r[k] <= 32'd0;
                end
            end else if (enable_i) begin
                chain_r[0] <= result_i[j];
                for (int k = 1; k < DEPTH; k++) begin
                    chain_r[k] <= chain_r[k-1];
                end
            end
        end

        assign row_data_o[j] = chain_r[DEPTH-1];
    end

    // Emitted-row counter. It advances once per output valid pulse and wraps
    // naturally at its width.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            row_count_r <= '0;
        end else if (row_valid_r) begin
            row_count_r <= row_count_r + COUNT_WIDTH'(1);
        end
    end

    // Busy while any row sits in the in-flight tag stages.
    always_comb begin
        busy_s = 1'b0;
        for (int i = 0; i < TAG_STAGES; i++) begin
            busy_s = busy_s | tag_valid_r[i];
        end
    end

    assign row_valid_o = row_valid_r;
    assign row_addr_o  = row_addr_r;
    assign row_acc_o   = row_acc_r;
    assign row_count_o = row_count_r;
    assign busy_o      = busy_s;

endmodule

// File: tb/tb_cellrv32_npu_result_deskew.sv
// Testbench for cellrv32_npu_result_deskew. The reference model keeps a
// history of the inputs seen on every enabled edge since the last reset. A row
// whose column 0 was captured on enabled edge k is expected after enabled edge
// k+MW-1, with column j taken from enabled edge k+j.
module tb_cellrv32_npu_result_deskew;

    localparam int MW   = 14;
    localparam int AW   = 8;
    localparam int CW   = 4;
    localparam int HMAX = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, en, vld, acc;
    logic [AW-1:0] addr;
    logic [31:0]   res_d    [0:MW-1];
    logic [31:0]   row_data [0:MW-1];
    logic          row_valid, row_acc, busy;
    logic [AW-1:0] row_addr;
    logic [CW-1:0] row_count;

    cellrv32_npu_result_deskew #(
        .MATRIX_WIDTH(MW),
        .ADDR_WIDTH  (AW),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (en),
        .result_i   (res_d),
        .res_valid_i(vld),
        .res_addr_i (addr),
        .res_acc_i  (acc),
        .row_data_o (row_data),
        .row_valid_o(row_valid),
        .row_addr_o (row_addr),
        .row_acc_o  (row_acc),
        .busy_o     (busy),
        .row_count_o(row_count)
    );

    int checks = 0;
    int errors = 0;

    // reference model state: history of enabled edges since reset
    logic          hv [0:HMAX-1];
    logic [AW-1:0] ha [0:HMAX-1];
    logic          hc [0:HMAX-1];
    logic [31:0]   hd [0:HMAX-1][0:MW-1];
    int            n = 0;
    bit            en_prev = 1'b0;
    bit            exp_valid = 1'b0;
    bit            just_reset = 1'b0;
    logic [CW-1:0] exp_cnt = '0;
    int            pulses = 0;
    logic [31:0]   last_data [0:MW-1];
    logic [AW-1:0] last_addr;
    logic          last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // one clock: update model on the edge, compare outputs 1 time unit later
    task automatic cycle();
        bit eb;
        int kb;
        @(posedge clk);
        if (rst) begin
            n          = 0;
            exp_cnt    = '0;
            en_prev    = 1'b0;
            just_reset = 1'b1;
        end else begin
            if (exp_valid) exp_cnt = exp_cnt + 4'd1;
            just_reset = 1'b0;
            if (en) begin
                if (n < HMAX) begin
                    hv[n] = vld;
                    ha[n] = addr;
                    hc[n] = acc;
                    for (int j = 0; j < MW; j++) hd[n][j] = res_d[j];
                end
                n++;
                en_prev = 1'b1;
            end else begin
                en_prev = 1'b0;
            end
        end
        exp_valid = 1'b0;
        if (en_prev && n >= MW) exp_valid = hv[n-MW];
        eb = 1'b0;
        kb = (n - MW + 1 > 0) ? n - MW + 1 : 0;
        for (int k = kb; k < n; k++) eb = eb | hv[k];
        #1;
        chk("row_valid", row_valid, exp_valid);
        chk("busy", busy, eb);
        chk("row_count", row_count, exp_cnt);
        if (exp_valid) begin
            chk("row_addr", row_addr, ha[n-MW]);
            chk("row_acc", row_acc, hc[n-MW]);
            for (int j = 0; j < MW; j++) chk("row_data", row_data[j], hd[n-MW+j][j]);
        end
        if (just_reset) begin
            chk("rst_addr", row_addr, 0);
            chk("rst_acc", row_acc, 0);
            for (int j = 0; j < MW; j++) chk("rst_data", row_data[j], 0);
        end
        if (row_valid === 1'b1) begin
            pulses++;
            for (int j = 0; j < MW; j++) last_data[j] = row_data[j];
            last_addr = row_addr;
            last_acc  = row_acc;
        end
    endtask

    task automatic drive(input logic e, input logic v, input logic [AW-1:0] a, input logic c);
        en   = e;
        vld  = v;
        addr = a;
        acc  = c;
        for (int j = 0; j < MW; j++) res_d[j] = $urandom;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            drive(1'b1, 1'b0, 8'h00, 1'b0);
            cycle();
        end
    endtask

    int p0;

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        cycle();
        cycle();
        rst = 1'b0;

        // single row, column j carries 100+j whenever it is sampled
        drive(1'b1, 1'b1, 8'h05, 1'b1);
        for (int j = 0; j < MW; j++) res_d[j] = 32'd100 + 32'(j);
        p0 = pulses;
        cycle();
        vld = 1'b0;
        for (int i = 0; i < MW + 2; i++) cycle();
        chk("single_pulses", pulses - p0, 1);
        chk("single_d0", last_data[0], 32'd100);
        chk("single_dlast", last_data[MW-1], 32'd100 + 32'(MW-1));
        chk("single_addr", last_addr, 8'h05);
        chk("single_acc", last_acc, 1'b1);
        chk("single_count", row_count, 4'd1);

        // six back-to-back rows
        p0 = pulses;
        for (int r = 0; r < 6; r++) begin
            drive(1'b1, 1'b1, 8'(r), r[0]);
            cycle();
        end
        idle(MW + 2);
        chk("b2b_pulses", pulses - p0, 6);
        chk("b2b_count", row_count, 4'd7);

        // stall mid-flight: 3 disabled cycles after the second enabled edge
        p0 = pulses;
        drive(1'b1, 1'b1, 8'h05, 1'b1);
        for (int j = 0; j < MW; j++) res_d[j] = 32'd100 + 32'(j);
        cycle();
        vld = 1'b0;
        cycle();
        en = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        en = 1'b1;
        for (int i = 0; i < MW + 2; i++) cycle();
        chk("stall_pulses", pulses - p0, 1);
        chk("stall_d0", last_data[0], 32'd100);
        chk("stall_d5", last_data[5], 32'd105);

        // reset mid-flight discards both rows
        drive(1'b1, 1'b1, 8'h11, 1'b0);
        cycle();
        drive(1'b1, 1'b1, 8'h22, 1'b1);
        cycle();
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        p0 = pulses;
        idle(MW + 6);
        chk("rst_pulses", pulses - p0, 0);
        chk("rst_count", row_count, 4'd0);
        chk("rst_busy", busy, 1'b0);

        // 17 rows wrap the 4-bit counter to 1
        for (int r = 0; r < 17; r++) begin
            drive(1'b1, 1'b1, 8'(r), 1'b0);
            cycle();
        end
        idle(MW + 2);
        chk("wrap_count", row_count, 4'd1);

        // randomized traffic with stalls and occasional resets
        for (int i = 0; i < 900; i++) begin
            drive(($urandom_range(3, 0) != 0), $urandom_range(1, 0) != 0,
                  8'($urandom), $urandom_range(1, 0) != 0);
            rst = ($urandom_range(99, 0) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(MW + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
